// File: rtl/program_loader_if.sv
// program_loader_if: byte-stream input plus memory-write / boot-status bundle.
// slave = loader side, master = stream source and memory/CPU side.
interface program_loader_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_rst;
  logic              load_done;
  logic              load_err;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output cpu_rst,
    output load_done,
    output load_err
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  cpu_rst,
    input  load_done,
    input  load_err
  );
endinterface

// File: rtl/program_loader.sv
// program_loader: framed byte-stream boot loader writing 32-bit memory words.
// Define LOADER_CHECKSUM_EN for a per-frame trailing checksum byte.
module program_loader #(
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 1024
) (
  input  logic             clk,
  input  logic             rst,
  program_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_HADDR,
    S_HCNT,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [33:0] LIMIT =
    34'(MEM_WORDS) * 34'd4;

  state_t            r_state;
  logic [1:0]        r_bcnt;
  logic [23:0]       r_shift;
  logic [31:0]       r_addr;
  logic [31:0]       r_cnt;
  logic [7:0]        r_sum;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_cpu_rst;
  logic              r_done;
  logic              r_err;

  logic              w_accept;
  logic              w_xfer;
  logic              w_last;
  logic [31:0]       w_word;
  logic [33:0]       w_end;
  logic [7:0]        w_csum;

  always_comb begin
    w_accept = 1'b0;
    unique case (r_state)
      S_HADDR, S_HCNT,
      S_DATA, S_CSUM: w_accept = 1'b1;
      default:        w_accept = 1'b0;
    endcase
  end

  // Held low while rst is asserted, independent of the clock.
  assign bus.in_ready  = rst & w_accept;
  assign w_xfer        = bus.in_valid & bus.in_ready;
  assign w_last        = (r_bcnt == 2'd3);
  assign w_word        = {bus.in_data, r_shift};
  assign w_end         = {2'b00, r_addr}
                       + {w_word, 2'b00};
  assign w_csum        = r_sum + bus.in_data;

  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.cpu_rst   = r_cpu_rst;
  assign bus.load_done = r_done;
  assign bus.load_err  = r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_HADDR;
      r_bcnt      <= 2'd0;
      r_shift     <= '0;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_rst   <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      if (w_xfer) begin
        r_shift <= w_word[31:8];
        r_bcnt  <= r_bcnt + 2'd1;
      end
      unique case (r_state)
        S_HADDR: begin
          if (w_xfer && w_last) begin
            r_addr  <= w_word;
            r_state <= S_HCNT;
          end
        end
        S_HCNT: begin
          if (w_xfer && w_last) begin
            r_cnt <= w_word;
            r_sum <= '0;
            if (w_word == 32'd0) begin
              r_state   <= S_DONE;
              r_done    <= 1'b1;
              r_cpu_rst <= 1'b1;
            end else if (r_addr[1:0] != 2'd0
                      || w_end > LIMIT) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_sum <= w_csum;
            if (w_last) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= r_addr[ADDR_W-1:0];
              r_mem_wdata <= w_word;
              r_state     <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          r_addr <= r_addr + 32'd4;
          r_cnt  <= r_cnt - 32'd1;
          if (r_cnt == 32'd1) begin
`ifdef LOADER_CHECKSUM_EN
            r_state <= S_CSUM;
`else
            r_state <= S_HADDR;
`endif
          end else begin
            r_state <= S_DATA;
          end
        end
        S_CSUM: begin
          if (w_xfer) begin
            r_bcnt <= 2'd0;
            if (w_csum == 8'd0) begin
              r_state <= S_HADDR;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
        end
        S_DONE, S_ERR: begin
        end
        default: r_state <= S_ERR;
      endcase
    end
  end

endmodule
